clock_divider_multi: RTL and testbench
======================================

// Module: clock_divider_multi
// PURPOSE
//   N-channel programmable clock/tick generator. Successor to the fixed 50 MHz -> 40 us divider.
//   Each channel divides clk_in by a runtime-programmable divisor, in toggle (square clock) or
//   pulse (1-cycle strobe) mode, with per-channel enable.
//   Divisor/mode updates are hitless: they take effect at the channel's next terminal count.
//   Feeds timing strobes (sampling, LCD/sensor bit timing) across the SoC.
// PARAMETERS
//   N_CH         4     number of independent channels (1..16)
//   DIV_W        16    divisor/counter width, bits
//   DEFAULT_DIV  2000  divisor loaded at reset (all channels)
//   DEFAULT_MODE 1     reset mode: 1 = toggle, 0 = pulse
// PORTS
//   clk_in     in   1                  single system clock (50 MHz)
//   rst        in   1                  synchronous reset, active-high
//   ch_en      in   N_CH               per-channel run enable, level
//   cfg_valid  in   1                  config write request
//   cfg_ready  out  1                  config write can be accepted
//   cfg_ch     in   $clog2(N_CH)       target channel (out-of-range: accepted, ignored)
//   cfg_div    in   DIV_W              new divisor D (0 treated as 1)
//   cfg_mode   in   1                  new mode (1 toggle, 0 pulse)
//   tick       out  N_CH               registered 1-cycle strobe, once per D cycles per channel
//   clk_out    out  N_CH               registered divided output
//   busy       out  N_CH               channel has an update pending
// BEHAVIOUR
//   Reset, sync, any cycle incl. mid-count or mid-update:
//     cnt = 0; div = DEFAULT_DIV; mode = DEFAULT_MODE; pend = 0.
//     tick = 0; clk_out = 0; busy = 0; cfg_ready = 1.
//   Counter, per channel: ch_en = 1 -> cnt counts 0..D-1 and wraps to 0. Terminal count TC = (cnt == D-1).
//   tick <= ch_en & TC. First tick is D cycles after the first cycle ch_en is sampled high.
//   Toggle mode: clk_out flips on the TC edge -> period 2*D, 50% duty.
//     D = 1 gives clk_in/2 with tick held high.
//   Pulse mode: clk_out <= ch_en & TC, identical to tick.
//   ch_en = 0: cnt held 0; tick = 0; clk_out forced 0 next cycle. Re-enable restarts from cnt 0.
//   Config handshake:
//     - Write accepted on cycle with cfg_valid & cfg_ready.
//     - cfg_ready = ~pend[cfg_ch] (combinational from cfg_ch and state).
//     - Out-of-range cfg_ch: ready = 1, no effect.
//   Update application:
//     - Target channel disabled (ch_en = 0 that cycle): div/mode load next edge. No pend.
//     - Target enabled: value parked in pending regs, pend = 1, busy = 1.
//       At the next TC edge: div/mode <- pending, cnt <- 0, pend <- 0.
//     - The TC that applies the update still produces its tick, computed with the old mode.
//     - Mode change toggle -> pulse: clk_out resolves to pulse semantics from the applying edge.
//   Simultaneous events:
//     - Write accepted on a cycle where target TC = 1: TC uses the old divisor; the new one
//       applies at the following TC (D_old cycles later).
//     - ch_en falling while pend = 1: pending applied immediately on that edge; pend cleared.
//     - Decreasing D below the current cnt cannot occur, because updates apply only at TC.
//   Widths: D is unsigned DIV_W. D-1 computed in DIV_W bits after the 0->1 clamp. No overflow.
//   Latency:
//     - ch_en rise -> first tick: D cycles.
//     - Config accept -> effect: 1 cycle if disabled, <= D_old cycles if enabled.
// STRUCTURE
//   Package clkdiv_pkg:
//     - typedef enum logic {MODE_PULSE = 0, MODE_TOGGLE = 1} clkdiv_mode_e.
//     - localparam DIV_W_MAX = 32.
//   Sub-module clock_divider_ch: one channel (cnt, div, mode, pending regs, tick/clk_out).
//     Port-level inputs: en, wr, wr_div, wr_mode.
//     Instantiated N_CH times via generate.
//   Top level: cfg_ch decode, cfg_ready mux, busy/tick/clk_out concatenation.
// TESTING
//   1. Reset, DEFAULT_DIV = 2000, ch0 enabled -> first tick at cycle 2000; clk_out toggles every
//      2000 cycles (period 80 us at 50 MHz).
//   2. Channel disabled, write D = 4, mode = toggle, then enable at cycle 0 -> tick at cycles 4, 8, 12;
//      clk_out high cycles 4-7, low 8-11.
//   3. Channel running D = 10, write D = 3 mid-count:
//      - busy = 1, cfg_ready = 0 for that channel until the next TC.
//      - Then ticks every 3 cycles; second write while busy is stalled.
//   4. D = 0 and D = 1 in both modes:
//      - Pulse: tick every cycle.
//      - Toggle: clk_out = clk_in/2.
//      - No X on any output.
//   5. Write coinciding with TC: the old period completes once more, then the new D applies.
//      ch_en dropped while pend: the new D is applied and pend cleared on that edge.
//   6. rst asserted mid-count with pend = 1 on all channels -> all outputs 0, busy = 0,
//      divisors back to DEFAULT_DIV next cycle.
//      Out-of-range cfg_ch write -> no channel changes.

Source files
------------

// File: rtl/clock_divider_multi_pkg.sv
// Shared types and helpers for the multi-channel clock/tick divider.
package clkdiv_pkg;

    typedef enum logic {
        MODE_PULSE  = 1'b0,
        MODE_TOGGLE = 1'b1
    } clkdiv_mode_e;

    localparam int DIV_W_MAX = 32;

    // A programmed divisor of 0 behaves exactly like 1.
    function automatic logic [DIV_W_MAX-1:0] div_clamp(input logic [DIV_W_MAX-1:0] d);
        return (d == '0) ? DIV_W_MAX'(1) : d;
    endfunction

endpackage

// File: rtl/clock_divider_ch.sv
// One divider channel: counter, active and pending config, registered tick/clk_out.
module clock_divider_ch
    import clkdiv_pkg::*;
#(
    parameter int DIV_W        = 16,
    parameter int DEFAULT_DIV  = 2000,
    parameter int DEFAULT_MODE = 1
) (
    input  logic             i_clk_in,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_wr,
    input  logic [DIV_W-1:0] i_wr_div,
    input  logic             i_wr_mode,
    output logic             o_tick,
    output logic             o_clk_out,
    output logic             o_busy
);

    localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(DEFAULT_DIV);
    localparam clkdiv_mode_e     RST_MODE = (DEFAULT_MODE != 0) ? MODE_TOGGLE : MODE_PULSE;

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_pdiv;
    clkdiv_mode_e     r_mode;
    clkdiv_mode_e     r_pmode;
    logic             r_pend;
    logic             r_tick;
    logic             r_clk;

    logic [DIV_W-1:0] w_last;
    logic             w_tc;
    logic             w_clk_tc;

    assign w_last = DIV_W'(div_clamp(DIV_W_MAX'(r_div)) - 1);
    assign w_tc   = (r_cnt == w_last);

    // On a terminal count the old mode decides, unless a pending switch to pulse lands on
    // this same edge, in which case clk_out already follows pulse semantics.
    assign w_clk_tc = (r_mode == MODE_TOGGLE && !(r_pend && r_pmode == MODE_PULSE)) ?
                      ~r_clk : 1'b1;

    always_ff @(posedge i_clk_in) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_div   <= RST_DIV;
            r_mode  <= RST_MODE;
            r_pdiv  <= RST_DIV;
            r_pmode <= RST_MODE;
            r_pend  <= 1'b0;
            r_tick  <= 1'b0;
            r_clk   <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_clk  <= 1'b0;
            if (i_wr) begin
                r_div  <= i_wr_div;
                r_mode <= clkdiv_mode_e'(i_wr_mode);
            end else if (r_pend) begin
                r_div  <= r_pdiv;
                r_mode <= r_pmode;
                r_pend <= 1'b0;
            end
        end else begin
            r_tick <= w_tc;
            if (w_tc) begin
                r_cnt <= '0;
                r_clk <= w_clk_tc;
                if (r_pend) begin
                    r_div  <= r_pdiv;
                    r_mode <= r_pmode;
                    r_pend <= 1'b0;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
                if (r_mode == MODE_PULSE) r_clk <= 1'b0;
            end
            // A running channel only ever changes config at a terminal count.
            if (i_wr) begin
                r_pdiv  <= i_wr_div;
                r_pmode <= clkdiv_mode_e'(i_wr_mode);
                r_pend  <= 1'b1;
            end
        end
    end

    assign o_tick    = r_tick;
    assign o_clk_out = r_clk;
    assign o_busy    = r_pend;

endmodule

// File: rtl/clock_divider_multi.sv
// N-channel programmable clock/tick generator with hitless per-channel config writes.
module clock_divider_multi
    import clkdiv_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int DIV_W        = 16,
    parameter int DEFAULT_DIV  = 2000,
    parameter int DEFAULT_MODE = 1,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             i_clk_in,
    input  logic             i_rst,
    input  logic [N_CH-1:0]  i_ch_en,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [CH_W-1:0]  i_cfg_ch,
    input  logic [DIV_W-1:0] i_cfg_div,
    input  logic             i_cfg_mode,
    output logic [N_CH-1:0]  o_tick,
    output logic [N_CH-1:0]  o_clk_out,
    output logic [N_CH-1:0]  o_busy
);

    logic [N_CH-1:0] w_wr;
    logic [N_CH-1:0] w_busy;
    logic            w_ready;
    logic            w_accept;

    // Out-of-range channel numbers never match, so they read ready and are dropped.
    always_comb begin
        w_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (i_cfg_ch == CH_W'(i)) w_ready = ~w_busy[i];
        end
    end

    assign o_cfg_ready = w_ready;
    assign w_accept    = i_cfg_valid & w_ready;
    assign o_busy      = w_busy;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign w_wr[g] = w_accept & (i_cfg_ch == CH_W'(g));

        clock_divider_ch #(
            .DIV_W        (DIV_W),
            .DEFAULT_DIV  (DEFAULT_DIV),
            .DEFAULT_MODE (DEFAULT_MODE)
        ) u_ch (
            .i_clk_in  (i_clk_in),
            .i_rst     (i_rst),
            .i_en      (i_ch_en[g]),
            .i_wr      (w_wr[g]),
            .i_wr_div  (i_cfg_div),
            .i_wr_mode (i_cfg_mode),
            .o_tick    (o_tick[g]),
            .o_clk_out (o_clk_out[g]),
            .o_busy    (w_busy[g])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: directed tables, reset/out-of-range sequences, random vs model.
module tb_clock_divider_multi;

    localparam int N_CH = 3;
    localparam int DIV_W = 16;
    localparam int DEF_DIV = 2000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N_CH-1:0]  ch_en = '0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [1:0]       cfg_ch = '0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic             cfg_mode = 1'b0;
    logic [N_CH-1:0]  tick, clk_out, busy;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    clock_divider_multi #(.N_CH(N_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEF_DIV), .DEFAULT_MODE(1)) dut (
        .i_clk_in(clk), .i_rst(rst), .i_ch_en(ch_en), .i_cfg_valid(cfg_valid),
        .o_cfg_ready(cfg_ready), .i_cfg_ch(cfg_ch), .i_cfg_div(cfg_div), .i_cfg_mode(cfg_mode),
        .o_tick(tick), .o_clk_out(clk_out), .o_busy(busy));

    // Reference model: per channel, cycles elapsed since the period origin plus config.
    int              m_e [N_CH];
    int              m_d [N_CH];
    int              m_pd[N_CH];
    bit [N_CH-1:0]   m_mode, m_pm, m_pend, m_tick, m_clk;
    bit              m_init = 1'b0;
    logic            seen_rdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        if (int'(cfg_ch) >= N_CH) return 1'b1;
        return !m_pend[cfg_ch];
    endfunction

    task automatic model_step(input bit rdy);
        bit wr, tc;
        int d;
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                m_e[c] = 0; m_d[c] = DEF_DIV; m_pd[c] = DEF_DIV;
            end
            m_mode = '1; m_pm = '1; m_pend = '0; m_tick = '0; m_clk = '0;
            m_init = 1'b1;
            return;
        end
        for (int c = 0; c < N_CH; c++) begin
            wr = cfg_valid && rdy && (int'(cfg_ch) == c);
            d  = (m_d[c] == 0) ? 1 : m_d[c];
            if (!ch_en[c]) begin
                m_e[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
                if (wr) begin
                    m_d[c] = int'(cfg_div); m_mode[c] = cfg_mode;
                end else if (m_pend[c]) begin
                    m_d[c] = m_pd[c]; m_mode[c] = m_pm[c]; m_pend[c] = 0;
                end
            end else begin
                tc = ((m_e[c] + 1) % d) == 0;
                m_tick[c] = tc;
                if (tc) m_clk[c] = (m_mode[c] && !(m_pend[c] && !m_pm[c])) ? !m_clk[c] : 1'b1;
                else if (!m_mode[c]) m_clk[c] = 1'b0;
                if (tc && m_pend[c]) begin
                    m_d[c] = m_pd[c]; m_mode[c] = m_pm[c]; m_pend[c] = 0; m_e[c] = 0;
                end else begin
                    m_e[c]++;
                end
                if (wr) begin
                    m_pd[c] = int'(cfg_div); m_pm[c] = cfg_mode; m_pend[c] = 1;
                end
            end
        end
    endtask

    // One clock: check ready before the edge, then outputs just after it.
    task automatic cycle();
        bit er;
        #1;
        er = m_ready();
        seen_rdy = cfg_ready;
        if (m_init) chk("m_ready", cfg_ready, er);
        @(posedge clk);
        #1;
        model_step(er);
        if (m_init) begin
            chk("m_tick", tick, m_tick);
            chk("m_clk_out", clk_out, m_clk);
            chk("m_busy", busy, m_pend);
        end
    endtask

    typedef struct {
        bit en; bit vld; int ch; int dv; bit md;
        bit rdy; bit tk; bit ck; bit bz;
    } vec_t;
    vec_t tv[$];

    function automatic void add(bit en, bit vld, int ch, int dv, bit md,
                                bit rdy, bit tk, bit ck, bit bz);
        vec_t v;
        v = '{en, vld, ch, dv, md, rdy, tk, ck, bz};
        tv.push_back(v);
    endfunction

    initial begin
        // Enable after a disabled write of D=4 toggle on ch1.
        add(0,1,1,4,1, 1,0,0,0);
        for (int k = 1; k <= 13; k++) add(1,0,1,0,0, 1, (k % 4) == 0, ((k / 4) % 2) == 1, 0);
        // ch2 at D=10, rewritten to D=3 mid-count; second write stalls.
        add(0,1,2,10,1, 1,0,0,0);
        for (int k = 1; k <= 5; k++) add(1,0,2,0,0, 1,0,0,0);
        add(1,1,2,3,1, 1,0,0,1);
        add(1,1,2,5,1, 0,0,0,1);
        add(1,0,2,0,0, 0,0,0,1);
        add(1,0,2,0,0, 0,0,0,1);
        add(1,0,2,0,0, 0,1,1,0);
        add(1,0,2,0,0, 1,0,1,0);
        add(1,0,2,0,0, 1,0,1,0);
        add(1,0,2,0,0, 1,1,0,0);
        add(1,0,2,0,0, 1,0,0,0);
        add(1,0,2,0,0, 1,0,0,0);
        add(1,0,2,0,0, 1,1,1,0);
        // ch0: write on the TC cycle, then ch_en drop while pending.
        add(0,1,0,4,1, 1,0,0,0);
        for (int k = 1; k <= 3; k++) add(1,0,0,0,0, 1,0,0,0);
        add(1,1,0,2,1, 1,1,1,1);
        for (int k = 5; k <= 7; k++) add(1,0,0,0,0, 0,0,1,1);
        add(1,0,0,0,0, 0,1,0,0);
        add(1,0,0,0,0, 1,0,0,0);
        add(1,0,0,0,0, 1,1,1,0);
        add(1,0,0,0,0, 1,0,1,0);
        add(1,0,0,0,0, 1,1,0,0);
        add(1,1,0,7,0, 1,0,0,1);
        add(0,0,0,0,0, 0,0,0,0);
        for (int k = 15; k <= 20; k++) add(1,0,0,0,0, 1,0,0,0);
        add(1,0,0,0,0, 1,1,1,0);
        add(1,0,0,0,0, 1,0,0,0);
        // ch1: D=0 and D=1 in both modes.
        add(0,1,1,0,0, 1,0,0,0);
        for (int k = 1; k <= 4; k++) add(1,0,1,0,0, 1,1,1,0);
        add(0,1,1,1,1, 1,0,0,0);
        for (int k = 1; k <= 4; k++) add(1,0,1,0,0, 1,1,k % 2,0);
        add(0,1,1,0,1, 1,0,0,0);
        for (int k = 1; k <= 4; k++) add(1,0,1,0,0, 1,1,k % 2,0);
        add(0,1,1,1,0, 1,0,0,0);
        for (int k = 1; k <= 3; k++) add(1,0,1,0,0, 1,1,1,0);

        // Reset state.
        rst = 1'b1;
        cycle();
        cycle();
        chk("rst_tick", tick, 0);
        chk("rst_clk_out", clk_out, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        chk("rst_ready", cfg_ready, 1);

        // Default divisor on ch0.
        ch_en = 3'b001;
        for (int k = 1; k <= 4000; k++) begin
            cycle();
            chk($sformatf("def_tick k=%0d", k), tick[0], (k % DEF_DIV) == 0);
            chk($sformatf("def_clk k=%0d", k), clk_out[0], ((k / DEF_DIV) % 2) == 1);
        end

        foreach (tv[i]) begin
            ch_en = '0;
            ch_en[tv[i].ch] = tv[i].en;
            cfg_valid = tv[i].vld;
            cfg_ch = 2'(tv[i].ch);
            cfg_div = DIV_W'(tv[i].dv);
            cfg_mode = tv[i].md;
            cycle();
            chk($sformatf("tv%0d_ready", i), seen_rdy, tv[i].rdy);
            chk($sformatf("tv%0d_tick", i), tick[tv[i].ch], tv[i].tk);
            chk($sformatf("tv%0d_clk_out", i), clk_out[tv[i].ch], tv[i].ck);
            chk($sformatf("tv%0d_busy", i), busy[tv[i].ch], tv[i].bz);
        end
        cfg_valid = 1'b0;

        // Reset with an update pending on every running channel.
        ch_en = '0;
        for (int c = 0; c < N_CH; c++) begin
            cfg_valid = 1'b1; cfg_ch = 2'(c); cfg_div = 16'd50; cfg_mode = 1'b1;
            cycle();
        end
        cfg_valid = 1'b0;
        ch_en = '1;
        repeat (10) cycle();
        for (int c = 0; c < N_CH; c++) begin
            cfg_valid = 1'b1; cfg_ch = 2'(c); cfg_div = 16'd7; cfg_mode = 1'b0;
            cycle();
        end
        cfg_valid = 1'b0;
        repeat (3) cycle();
        chk("pre_rst_busy", busy, 3'b111);
        rst = 1'b1;
        cycle();
        chk("mid_rst_tick", tick, 0);
        chk("mid_rst_clk_out", clk_out, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        for (int k = 1; k <= 4000; k++) begin
            cfg_valid = (k == 2500);
            cfg_ch = 2'd3; cfg_div = 16'd3; cfg_mode = 1'b0;
            cycle();
            if (k == 2500) chk("oor_ready", seen_rdy, 1);
            chk($sformatf("post_rst_tick k=%0d", k), tick, ((k % DEF_DIV) == 0) ? 3'b111 : 3'b000);
            chk($sformatf("post_rst_clk k=%0d", k), clk_out, (((k / DEF_DIV) % 2) == 1) ? 3'b111 : 3'b000);
            chk($sformatf("post_rst_busy k=%0d", k), busy, 0);
        end
        cfg_valid = 1'b0;

        // Random traffic with small divisors, checked against the model every cycle.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        ch_en = '0;
        for (int k = 0; k < 6000; k++) begin
            if (k >= 30 && $urandom_range(0, 24) == 0) ch_en[$urandom_range(0, N_CH - 1)] ^= 1'b1;
            if (k == 30) ch_en = '1;
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_ch = 2'($urandom_range(0, 3));
            cfg_div = DIV_W'($urandom_range(0, 6));
            cfg_mode = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
